// File: rtl/isram_if.sv
// SimpleBus fetch port between the IFU and the instruction SRAM responder,
// plus the word-read port toward the backing memory model.
interface isram_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          req_valid;
  logic [AW-1:0] raddr;
  logic          resp_valid;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          req_drop;
  // Memory read strobe/address are combinational; mem_rdata returns in the same cycle.
  logic          mem_en_c;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req_valid, raddr, mem_rdata,
    output resp_valid, rdata, busy, req_drop, mem_en_c, mem_addr_c
  );

  modport master (
    output req_valid, raddr, mem_rdata,
    input  resp_valid, rdata, busy, req_drop, mem_en_c, mem_addr_c
  );
endinterface

// File: rtl/isram.sv
// Instruction SRAM responder: one outstanding fetch, fixed or LFSR-randomised
// latency, single-cycle response pulse with rdata held until the next response.
module isram #(
  parameter int unsigned LAT_MIN   = 1,
  parameter int unsigned LAT_RAND  = 0,
  parameter logic [7:0]  LAT_MASK  = 8'h03,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic   clk,
  input  logic   rst,
  isram_if.slave bus
);
  localparam int unsigned CW = 9;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    lfsr, lfsr_nx;
  logic [AW-1:0] addr, addr_nx;
  logic [DW-1:0] rdata_nx;
  logic          resp_nx, busy_nx, drop_nx;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] lat;
  logic [AW-1:0] req_addr;
  logic [7:0]    lfsr_step;

  // Latency is drawn from the LFSR value before it steps.
  always_comb begin
    lat = CW'(LAT_MIN);
    if (LAT_RAND != 0) lat = CW'(LAT_MIN) + CW'(lfsr & LAT_MASK);
  end

  assign req_addr  = {bus.raddr[AW-1:2], 2'b00};
  // Galois form of x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_step = {lfsr[6:0], 1'b0} ^ (lfsr[7] ? 8'h71 : 8'h00);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lfsr_nx  = lfsr;
    addr_nx  = addr;
    rdata_nx = bus.rdata;
    drop_nx  = 1'b0;
    mem_en   = 1'b0;
    mem_addr = addr;
    case (state)
      S_IDLE, S_RESP: begin
        if (bus.req_valid) begin
          addr_nx = req_addr;
          cnt_nx  = lat - CW'(1);
          lfsr_nx = lfsr_step;
          if (lat == CW'(1)) begin
            mem_en   = 1'b1;
            mem_addr = req_addr;
            rdata_nx = bus.mem_rdata;
            state_nx = S_RESP;
          end else begin
            state_nx = S_BUSY;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_BUSY: begin
        drop_nx = bus.req_valid;
        cnt_nx  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          mem_en   = 1'b1;
          rdata_nx = bus.mem_rdata;
          state_nx = S_RESP;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    resp_nx = (state_nx == S_RESP);
    busy_nx = (state_nx != S_IDLE);
  end

  // A read strobe during reset would be discarded, so never show one.
  assign bus.mem_en_c   = mem_en & ~rst;
  assign bus.mem_addr_c = mem_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      lfsr           <= LFSR_SEED;
      addr           <= '0;
      bus.resp_valid <= 1'b0;
      bus.rdata      <= '0;
      bus.busy       <= 1'b0;
      bus.req_drop   <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      lfsr           <= lfsr_nx;
      addr           <= addr_nx;
      bus.resp_valid <= resp_nx;
      bus.rdata      <= rdata_nx;
      bus.busy       <= busy_nx;
      bus.req_drop   <= drop_nx;
    end
  end
endmodule

// File: tb/tb_isram.sv
// Bench for isram: four configurations share one request stream and are each
// checked every cycle against a transaction-level reference model.
module tb_isram;
  localparam int unsigned ND = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] raddr = '0;

  int ncmp = 0;
  int nerr = 0;
  int calls [ND];

  isram_if if0 ();
  isram_if if1 ();
  isram_if if2 ();
  isram_if if3 ();

  always #5 clk = ~clk;

  function automatic logic [31:0] pmem(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign if0.req_valid = req;  assign if0.raddr = raddr;
  assign if1.req_valid = req;  assign if1.raddr = raddr;
  assign if2.req_valid = req;  assign if2.raddr = raddr;
  assign if3.req_valid = req;  assign if3.raddr = raddr;
  assign if0.mem_rdata = pmem(if0.mem_addr_c);
  assign if1.mem_rdata = pmem(if1.mem_addr_c);
  assign if2.mem_rdata = pmem(if2.mem_addr_c);
  assign if3.mem_rdata = pmem(if3.mem_addr_c);

  isram #(.LAT_MIN(1), .LAT_RAND(0), .LAT_MASK(8'h03), .LFSR_SEED(8'hA5))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  isram #(.LAT_MIN(3), .LAT_RAND(0), .LAT_MASK(8'h03), .LFSR_SEED(8'hA5))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  isram #(.LAT_MIN(4), .LAT_RAND(0), .LAT_MASK(8'h03), .LFSR_SEED(8'hA5))
    dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  isram #(.LAT_MIN(1), .LAT_RAND(1), .LAT_MASK(8'h03), .LFSR_SEED(8'hA5))
    dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic        rv_o [ND];
  logic        bz_o [ND];
  logic        dr_o [ND];
  logic [31:0] rd_o [ND];
  assign rv_o[0] = if0.resp_valid; assign bz_o[0] = if0.busy;
  assign dr_o[0] = if0.req_drop;   assign rd_o[0] = if0.rdata;
  assign rv_o[1] = if1.resp_valid; assign bz_o[1] = if1.busy;
  assign dr_o[1] = if1.req_drop;   assign rd_o[1] = if1.rdata;
  assign rv_o[2] = if2.resp_valid; assign bz_o[2] = if2.busy;
  assign dr_o[2] = if2.req_drop;   assign rd_o[2] = if2.rdata;
  assign rv_o[3] = if3.resp_valid; assign bz_o[3] = if3.busy;
  assign dr_o[3] = if3.req_drop;   assign rd_o[3] = if3.rdata;

  // Observed memory reads, counted at the edge that performs them.
  initial for (int k = 0; k < ND; k++) calls[k] = 0;
  always @(posedge clk) begin
    if (if0.mem_en_c) calls[0] <= calls[0] + 1;
    if (if1.mem_en_c) calls[1] <= calls[1] + 1;
    if (if2.mem_en_c) calls[2] <= calls[2] + 1;
    if (if3.mem_en_c) calls[3] <= calls[3] + 1;
  end

  // Reference model: per configuration, the outstanding request and the cycle
  // in which its response is due, plus the data word it will return.
  int          lmin  [ND] = '{1, 3, 4, 1};
  bit          lrand [ND] = '{0, 0, 0, 1};
  longint      t = 0;
  bit          outst [ND];
  longint      due   [ND];
  logic [31:0] pend  [ND];
  logic [31:0] cur   [ND];
  logic [7:0]  lf    [ND];
  bit          drop  [ND];
  int          calls_exp [ND];

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic [7:0] n;
    n = (v << 1) & 8'hFF;
    if (v >= 8'h80) n = n ^ 8'h71;
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      outst[k] = 0; due[k] = 0; pend[k] = '0; cur[k] = '0;
      lf[k] = 8'hA5; drop[k] = 0;
    end
  endtask

  task automatic model_edge(input logic v, input logic [31:0] a);
    for (int k = 0; k < ND; k++) begin
      bit resp_now;
      int lat;
      if (rst) continue;
      resp_now = outst[k] && (due[k] == t);
      drop[k]  = 0;
      if (v && (!outst[k] || resp_now)) begin
        lat = lmin[k] + (lrand[k] ? int'(lf[k] & 8'h03) : 0);
        lf[k]    = lfsr_next(lf[k]);
        pend[k]  = pmem({a[31:2], 2'b00});
        due[k]   = t + lat;
        outst[k] = 1;
      end else begin
        if (v) drop[k] = 1;
        if (resp_now) outst[k] = 0;
      end
    end
    t++;
    for (int k = 0; k < ND; k++)
      if (outst[k] && due[k] == t) begin
        cur[k] = pend[k];
        calls_exp[k]++;
      end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("%s d%0d c%0d resp_valid", tag, k, t), 32'(rv_o[k]),
          32'(outst[k] && due[k] == t));
      chk($sformatf("%s d%0d c%0d busy", tag, k, t), 32'(bz_o[k]), 32'(outst[k]));
      chk($sformatf("%s d%0d c%0d req_drop", tag, k, t), 32'(dr_o[k]), 32'(drop[k]));
      chk($sformatf("%s d%0d c%0d rdata", tag, k, t), rd_o[k], cur[k]);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] a);
    req = v;
    raddr = a;
    @(posedge clk);
    model_edge(v, a);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 32'h0);
  endtask

  initial begin
    for (int k = 0; k < ND; k++) calls_exp[k] = 0;
    model_reset();
    #1;
    check_all("por");
    step("por", 1'b1, 32'h8000_0000);
    step("por", 1'b0, 32'h0);
    rst = 1'b0;

    step("single", 1'b1, 32'h8000_0000);
    idle("single", 8);
    step("unaligned", 1'b1, 32'h8000_0006);
    idle("unaligned", 8);
    step("b2b", 1'b1, 32'h8000_0000);
    step("b2b", 1'b1, 32'h8000_0004);
    idle("b2b", 8);
    step("drop", 1'b1, 32'h8000_0010);
    step("drop", 1'b0, 32'h0);
    step("drop", 1'b1, 32'h8000_0020);
    idle("drop", 8);

    for (int i = 0; i < 16; i++) begin
      step("seq", 1'b1, $urandom);
      idle("seq", 5);
    end
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 2) == 0), $urandom);
    for (int i = 0; i < 20; i++) step("held", 1'b1, $urandom);
    idle("held", 8);

    // Reset lands mid-cycle during the second BUSY cycle of the slow config.
    step("midrst", 1'b1, 32'h8000_0040);
    step("midrst", 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    step("midrst", 1'b1, 32'h8000_0080);
    step("midrst", 1'b1, 32'h8000_0084);
    rst = 1'b0;
    idle("midrst", 6);
    step("postrst", 1'b1, 32'h8000_0100);
    idle("postrst", 8);

    for (int k = 0; k < ND; k++)
      chk($sformatf("pmem_read count d%0d", k), 32'(calls[k]), 32'(calls_exp[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
